// File: rtl/prog_loader.sv
// Byte-stream program loader: length header, big-endian words, optional XOR checksum.
// Define PROG_LOADER_CSUM_EN to add the trailing checksum byte and its check.
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [15:0] im_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA_HI,
    DATA_LO,
`ifdef PROG_LOADER_CSUM_EN
    CSUM,
`endif
    RUN,
    ERROR
  } state_t;

`ifdef PROG_LOADER_CSUM_EN
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = RUN;
`endif

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t state, next;

  logic              accept;
  logic [7:0]        len_hi;
  logic [7:0]        hi;
  logic [15:0]       len_full;
  logic              len_zero;
  logic              len_big;
  logic [ADDR_W:0]   n;
  logic [ADDR_W:0]   word_index;
  logic [ADDR_W:0]   index_next;
  logic              last;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]        csum;
`endif

  assign accept     = in_valid && in_ready;
  assign len_full   = {len_hi, in_data};
  assign len_zero   = len_full == 16'd0;
  assign len_big    = {1'b0, len_full} > CAP;
  assign index_next = word_index + {{ADDR_W{1'b0}}, 1'b1};
  assign last       = index_next == n;

  always_ff @(posedge Clk) begin
    if (Rst) state <= HDR_HI;
    else     state <= next;
  end

  always_comb begin
    next     = state;
    in_ready = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    core_rst = 1'b1;
    unique case (state)
      HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) next = HDR_LO;
      end
      HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (len_big)       next = ERROR;
          else if (len_zero) next = AFTER_DATA;
          else               next = DATA_HI;
        end
      end
      DATA_HI: begin
        in_ready = 1'b1;
        if (in_valid) next = DATA_LO;
      end
      DATA_LO: begin
        in_ready = 1'b1;
        if (in_valid) next = last ? AFTER_DATA : DATA_HI;
      end
`ifdef PROG_LOADER_CSUM_EN
      CSUM: begin
        in_ready = 1'b1;
        if (in_valid) next = (in_data == csum) ? RUN : ERROR;
      end
`endif
      RUN: begin
        core_rst = 1'b0;
        done     = 1'b1;
      end
      ERROR: begin
        err = 1'b1;
      end
      default: next = HDR_HI;
    endcase
  end

  // Write strobe is registered so address and data are stable for its one cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      len_hi     <= '0;
      hi         <= '0;
      n          <= '0;
      word_index <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
`ifdef PROG_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      im_we <= 1'b0;
      if (accept) begin
        unique case (state)
          HDR_HI:  len_hi <= in_data;
          HDR_LO:  n <= len_full[ADDR_W:0];
          DATA_HI: begin
            hi <= in_data;
`ifdef PROG_LOADER_CSUM_EN
            csum <= csum ^ in_data;
`endif
          end
          DATA_LO: begin
            im_we      <= 1'b1;
            im_wdata   <= {hi, in_data};
            im_addr    <= 16'({word_index[ADDR_W-1:0], 1'b0});
            word_index <= index_next;
`ifdef PROG_LOADER_CSUM_EN
            csum <= csum ^ in_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized and directed streams against a stream-parsing reference model.
// Expectations follow PROG_LOADER_CSUM_EN the same way the design does.
module tb_prog_loader;

  localparam int AW = 10;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        im_we;
  logic [15:0] im_addr;
  logic [15:0] im_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  prog_loader #(.ADDR_W(AW)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int accepted;
  int exp_cnt;
  bit exp_done;
  bit exp_err;

  logic [7:0]  stream[$];
  logic [31:0] got[$];
  logic [31:0] exp_w[$];

  always @(negedge Clk)
    if (im_we) got.push_back({im_addr, im_wdata});

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    int nw;
    logic [7:0] x;
    exp_w.delete();
    x  = 8'h00;
    nw = int'({stream[0], stream[1]});
    if (nw > (1 << AW)) begin
      exp_cnt  = 2;
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    for (int i = 0; i < nw; i++) begin
      exp_w.push_back({16'(2 * i), stream[2 + 2 * i], stream[3 + 2 * i]});
      x = x ^ stream[2 + 2 * i] ^ stream[3 + 2 * i];
    end
`ifdef PROG_LOADER_CSUM_EN
    exp_cnt  = 2 * nw + 3;
    exp_done = stream[2 * nw + 2] == x;
    exp_err  = !exp_done;
`else
    exp_cnt  = 2 * nw + 2;
    exp_done = 1'b1;
    exp_err  = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    in_valid = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_im_wdata", 32'(im_wdata), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps,
                           output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge Clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        #1;
        if (in_ready) begin
          accepted++;
          ok = 1'b1;
        end
        return;
      end
    end
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_stream(input bit gaps, input bit rst);
    bit ok;
    int m;
    if (rst) do_reset();
    got.delete();
    accepted = 0;
    foreach (stream[i]) begin
      send_byte(stream[i], gaps, ok);
      if (!ok) break;
    end
    repeat (4) begin
      @(negedge Clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      #1;
      if (in_ready) accepted++;
    end
    @(negedge Clk);
    in_valid = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    model();
    check("accepted", 32'(accepted), 32'(exp_cnt));
    check("nwrites", 32'(got.size()), 32'(exp_w.size()));
    m = (got.size() < exp_w.size()) ? got.size() : exp_w.size();
    for (int i = 0; i < m; i++) check("write", got[i], exp_w[i]);
    check("done", 32'(done), 32'(exp_done));
    check("err", 32'(err), 32'(exp_err));
    check("core_rst", 32'(core_rst), 32'(!exp_done));
    check("in_ready_end", 32'(in_ready), 32'd0);
  endtask

  task automatic make_random(input int nw, input bit bad);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    stream.delete();
    stream.push_back(8'(nw >> 8));
    stream.push_back(8'(nw));
    if (nw > (1 << AW)) begin
      repeat (4) stream.push_back(8'($urandom));
      return;
    end
    for (int i = 0; i < 2 * nw; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      stream.push_back(b);
    end
    if (bad) stream.push_back(x ^ 8'(1 << $urandom_range(0, 7)));
    else     stream.push_back(x);
  endtask

  initial begin
    bit ok;
    int nw;
    int r;

    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_stream(1'b0, 1'b1);
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_stream(1'b0, 1'b1);
    stream = '{8'h04, 8'h01, 8'h00, 8'h00};
    run_stream(1'b0, 1'b1);
    stream = '{8'h00, 8'h00, 8'h00};
    run_stream(1'b0, 1'b1);
    stream = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
    run_stream(1'b1, 1'b1);

    do_reset();
    got.delete();
    send_byte(8'h00, 1'b0, ok);
    send_byte(8'h02, 1'b0, ok);
    send_byte(8'h12, 1'b0, ok);
    @(negedge Clk);
    in_valid = 1'b1;
    in_data  = 8'h34;
    Rst      = 1'b1;
    @(negedge Clk);
    Rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_core_rst", 32'(core_rst), 32'd1);
    repeat (3) @(negedge Clk);
    check("midrst_no_we", 32'(got.size()), 32'd0);
    stream = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'hFF};
    run_stream(1'b0, 1'b0);

    make_random(1 << AW, 1'b0);
    run_stream(1'b0, 1'b1);
    make_random((1 << AW) + 1, 1'b0);
    run_stream(1'b0, 1'b1);

    for (int k = 0; k < 10; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      nw = 0;
      else if (r == 1) nw = $urandom_range((1 << AW) + 1, 65535);
      else             nw = $urandom_range(1, 6);
      make_random(nw, $urandom_range(0, 2) == 0);
      run_stream(1'b1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
